axi_llc_way_arbiter: RTL and testbench
======================================

Name: axi_llc_way_arbiter

Overview:
Shares the single data-storage request port among the LLC cache units: read, write, evict and refill. The block round-robin arbitrates unit requests onto the data way port. For every read it records the originating unit and routes the in-order read response back to that unit. It sits between the cache units and the data way macros, and replaces point-to-point unit-to-way wiring.

Parameters:
NumUnits, 4, number of requesting cache units; index order is RChanUnit=0, WChanUnit=1, EvictUnit=2, RefilUnit=3.
MaxReads, axi_llc_pkg::DataMacroLatency + 2 (=3), depth of the routing FIFO, i.e. the maximum number of outstanding reads.
way_inp_t, logic, data way request payload; contains fields we and cache_unit.
way_oup_t, logic, data way response payload; contains field data.

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous reset, active low
test_i  in  1  testmode, forwarded to the FIFO
unit_req_i  in  NumUnits x $bits(way_inp_t)  per-unit request payload
unit_req_valid_i  in  NumUnits  per-unit request valid
unit_req_ready_o  out  NumUnits  per-unit request ready
way_inp_o  out  $bits(way_inp_t)  granted request to the data ways
way_inp_valid_o  out  1  request valid
way_inp_ready_i  in  1  data ways accept the request
way_out_i  in  $bits(way_oup_t)  read response from the data ways
way_out_valid_i  in  1  response valid
way_out_ready_o  out  1  response accepted
unit_rsp_o  out  $bits(way_oup_t)  response payload, broadcast to all units
unit_rsp_valid_o  out  NumUnits  one-hot response valid
unit_rsp_ready_i  in  NumUnits  per-unit response ready
busy_o  out  1  a request is pending, or reads are outstanding

Behaviour:
- Reset: the RR pointer resets to 0, the lock flag to 0 and the routing FIFO to empty. All ready/valid outputs are 0 and busy_o is 0.
- Eligibility:
  - Unit i is eligible when unit_req_valid_i[i] is high, AND either unit_req_i[i].we is 1 or the FIFO is not full.
  - Writes never consume FIFO space.
- Arbitration:
  - When unlocked, grant the first eligible unit at or after the RR pointer, scanning circularly.
  - way_inp_o is unit_req_i[grant], with cache_unit overwritten by the grant index. way_inp_valid_o is 1 if any unit is eligible.
- Stability:
  - If way_inp_valid_o is high and way_inp_ready_i is low, the lock flag is set and the grant index is registered.
  - The next cycle presents the same unit regardless of other arrivals. The lock clears on handshake.
  - Requesters must hold valid and payload until ready; this is AXI-like.
- Handshake:
  - unit_req_ready_o[grant] = way_inp_ready_i & way_inp_valid_o. All other units' ready is 0.
  - On handshake the RR pointer becomes (grant+1) mod NumUnits.
  - If we=0, the grant index is pushed into the FIFO in the same cycle.
- Latency: combinational request path, zero cycles. A request arriving with way_inp_ready_i high is forwarded in the same cycle.
- Response routing:
  - head is the FIFO output.
  - unit_rsp_valid_o[head] = way_out_valid_i & ~empty.
  - way_out_ready_o = unit_rsp_ready_i[head] & ~empty.
  - The FIFO pops on the response handshake. unit_rsp_o = way_out_i, combinational.
- Ordering: responses return in request order; only the FIFO head is ever served.
- Simultaneous push and pop while full: the pop frees space only in the next cycle; the push must see full deasserted. Eligibility uses the registered full flag (no fall-through).
- Response while the FIFO is empty: way_out_ready_o stays 0 and an assertion fires.
- FIFO depth: MaxReads reads may be outstanding. The (MaxReads+1)th read stalls while writes from other units still pass.
- busy_o = |unit_req_valid_i | ~empty.
- A unit_req_valid_i drop while locked is a protocol violation, checked by an assertion.
- Reset mid-operation clears the FIFO; in-flight macro responses are discarded by the system-level reset.

Decomposition:
- axi_llc_pkg holds the unit index constants (RChanUnit…) and DataMacroLatency.
- The request/response types are passed in as type parameters.
- Sub-modules:
  - The routing FIFO is fifo_v3 with FALL_THROUGH=0 and dtype logic[$clog2(NumUnits)-1:0].
  - The round-robin pick is the natural sub-module: rr_arb_tree with LockIn=1 and ExtPrio=0, or a local axi_llc_rr_pick.

Test Plan:
1. All 4 units issue reads in one cycle, with way_inp_ready_i=1 → grants in order 0,1,2,3 on consecutive cycles. The FIFO holds 0,1,2 and the 4th read stalls until the first response is popped.
2. Unit 1 is valid while way_inp_ready_i=0 for 3 cycles, and unit 0 becomes valid in cycle 2 → way_inp_o stays on unit 1 with a stable payload, then unit 0 is granted next.
3. Unit 1 issues writes (we=1) with the FIFO full of reads → writes are granted every cycle and nothing is pushed to the FIFO.
4. Reads from units 2 then 0, with responses D0 and D1 → unit_rsp_valid_o=4'b0100 with D0, then 4'b0001 with D1.
5. Response head is unit 3 with unit_rsp_ready_i[3]=0 for 2 cycles → way_out_ready_o=0 and the FIFO is unchanged; it pops on the cycle ready rises.
6. Assert rst_ni low while 2 reads are outstanding → all outputs are 0 and busy_o=0. After release, the first grant starts at unit 0.

Source files
------------

// File: rtl/axi_llc_pkg.sv
// rtl/axi_llc_pkg.sv - LLC cache-unit indices, data macro timing and default way payload types
package axi_llc_pkg;

    localparam int unsigned RChanUnit = 0;
    localparam int unsigned WChanUnit = 1;
    localparam int unsigned EvictUnit = 2;
    localparam int unsigned RefilUnit = 3;

    localparam int unsigned DataMacroLatency = 1;
    localparam int unsigned UnitIdxW = 2;

    typedef struct packed {
        logic                we;
        logic [UnitIdxW-1:0] cache_unit;
        logic [15:0]         addr;
        logic [31:0]         data;
    } llc_way_inp_t;

    typedef struct packed {
        logic [31:0] data;
    } llc_way_oup_t;

endpackage

// File: rtl/axi_llc_rr_pick.sv
// rtl/axi_llc_rr_pick.sv - combinational circular pick of the first request at or after the pointer
module axi_llc_rr_pick #(
    parameter int unsigned NumUnits = 4,
    parameter int unsigned IdxW     = $clog2(NumUnits)
) (
    input  logic [NumUnits-1:0] req,
    input  logic [IdxW-1:0]     ptr,
    output logic [IdxW-1:0]     idx,
    output logic                found
);
    logic [IdxW-1:0] cand;

    // scanning from the farthest offset down lets the nearest requester win
    always_comb begin
        idx   = ptr;
        found = 1'b0;
        cand  = '0;
        for (int off = int'(NumUnits) - 1; off >= 0; off--) begin
            cand = IdxW'((int'(ptr) + off) % int'(NumUnits));
            if (req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_llc_way_fifo.sv
// rtl/axi_llc_way_fifo.sv - non-fall-through routing FIFO holding the unit index of each outstanding read
module axi_llc_way_fifo #(
    parameter int unsigned Depth = 3,
    parameter int unsigned Width = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             test_mode,
    input  logic             push,
    input  logic [Width-1:0] wdata,
    input  logic             pop,
    output logic [Width-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;
    logic             unused_test_mode;

    assign unused_test_mode = test_mode;

    // full/empty derive from the registered count, so a pop frees space only next cycle
    assign full    = (count_q == CntW'(Depth));
    assign empty   = (count_q == '0);
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q <= (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_q <= (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/axi_llc_way_arbiter.sv
// rtl/axi_llc_way_arbiter.sv - round-robin sharing of the data way port with in-order read response routing
module axi_llc_way_arbiter
    import axi_llc_pkg::*;
#(
    parameter int unsigned NumUnits  = 4,
    parameter int unsigned MaxReads  = DataMacroLatency + 2,
    parameter type         way_inp_t = llc_way_inp_t,
    parameter type         way_oup_t = llc_way_oup_t
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    test_i,
    input  way_inp_t [NumUnits-1:0] unit_req_i,
    input  logic [NumUnits-1:0]     unit_req_valid_i,
    output logic [NumUnits-1:0]     unit_req_ready_o,
    output way_inp_t                way_inp_o,
    output logic                    way_inp_valid_o,
    input  logic                    way_inp_ready_i,
    input  way_oup_t                way_out_i,
    input  logic                    way_out_valid_i,
    output logic                    way_out_ready_o,
    output way_oup_t                unit_rsp_o,
    output logic [NumUnits-1:0]     unit_rsp_valid_o,
    input  logic [NumUnits-1:0]     unit_rsp_ready_i,
    output logic                    busy_o
);
    localparam int unsigned IdxW = $clog2(NumUnits);

    logic [IdxW-1:0]     rr_q, lock_idx_q, pick_idx, grant, head;
    logic                lock_q, any_elig, handshake;
    logic                full, empty, push, pop;
    logic [NumUnits-1:0] eligible;

    // reads need a free routing slot; writes never produce a response
    always_comb begin
        eligible = '0;
        for (int i = 0; i < int'(NumUnits); i++)
            eligible[i] = unit_req_valid_i[i] & (unit_req_i[i].we | ~full);
    end

    axi_llc_rr_pick #(.NumUnits(NumUnits), .IdxW(IdxW)) i_rr_pick (
        .req   (eligible),
        .ptr   (rr_q),
        .idx   (pick_idx),
        .found (any_elig)
    );

    assign grant           = lock_q ? lock_idx_q : pick_idx;
    assign way_inp_valid_o = lock_q ? eligible[lock_idx_q] : any_elig;
    assign handshake       = way_inp_valid_o & way_inp_ready_i;
    assign push            = handshake & ~way_inp_o.we;

    always_comb begin
        way_inp_o            = unit_req_i[grant];
        way_inp_o.cache_unit = grant;
        unit_req_ready_o        = '0;
        unit_req_ready_o[grant] = handshake;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else if (handshake) begin
            rr_q   <= (grant == IdxW'(NumUnits - 1)) ? '0 : grant + 1'b1;
            lock_q <= 1'b0;
        end else if (way_inp_valid_o) begin
            lock_q     <= 1'b1;
            lock_idx_q <= grant;
        end
    end

    axi_llc_way_fifo #(.Depth(MaxReads), .Width(IdxW)) i_route_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .test_mode (test_i),
        .push      (push),
        .wdata     (grant),
        .pop       (pop),
        .rdata     (head),
        .full      (full),
        .empty     (empty)
    );

    always_comb begin
        unit_rsp_valid_o       = '0;
        unit_rsp_valid_o[head] = way_out_valid_i & ~empty;
    end

    assign way_out_ready_o = unit_rsp_ready_i[head] & ~empty;
    assign pop             = way_out_valid_i & way_out_ready_o;
    assign unit_rsp_o      = way_out_i;
    assign busy_o          = (|unit_req_valid_i) | ~empty;

    a_rsp_without_read: assert property (@(posedge clk_i) disable iff (!rst_ni)
        way_out_valid_i |-> !empty);
    a_locked_valid_drop: assert property (@(posedge clk_i) disable iff (!rst_ni)
        lock_q |-> unit_req_valid_i[lock_idx_q]);

endmodule

// File: tb/tb_axi_llc_way_arbiter.sv
// tb/tb_axi_llc_way_arbiter.sv - directed bench with a queue-based reference model for the way arbiter
module tb_axi_llc_way_arbiter;
    import axi_llc_pkg::*;

    logic clk = 1'b0;
    logic rst_n, test;
    llc_way_inp_t [3:0] unit_req;
    logic [3:0]   unit_req_valid, unit_req_ready, unit_rsp_valid, unit_rsp_ready;
    llc_way_inp_t way_inp;
    logic         way_inp_valid, way_inp_ready;
    llc_way_oup_t way_out, unit_rsp;
    logic         way_out_valid, way_out_ready, busy;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    axi_llc_way_arbiter dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .test_i           (test),
        .unit_req_i       (unit_req),
        .unit_req_valid_i (unit_req_valid),
        .unit_req_ready_o (unit_req_ready),
        .way_inp_o        (way_inp),
        .way_inp_valid_o  (way_inp_valid),
        .way_inp_ready_i  (way_inp_ready),
        .way_out_i        (way_out),
        .way_out_valid_i  (way_out_valid),
        .way_out_ready_o  (way_out_ready),
        .unit_rsp_o       (unit_rsp),
        .unit_rsp_valid_o (unit_rsp_valid),
        .unit_rsp_ready_i (unit_rsp_ready),
        .busy_o           (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // reference model: outstanding reads as a queue of unit numbers, pointer as a plain int
    int   rr_m, lock_unit_m, g;
    bit   lock_m, v, full_m, nonempty;
    bit [3:0] elig, exp_ready, exp_rv;
    bit   exp_or;
    int   q[$];
    llc_way_inp_t exp_p;

    always @(negedge clk) begin
        if (!rst_n) begin
            rr_m = 0; lock_m = 0; lock_unit_m = 0; q.delete();
            check("rst_inp_valid", way_inp_valid, 0);
            check("rst_req_ready", unit_req_ready, 0);
            check("rst_rsp_valid", unit_rsp_valid, 0);
            check("rst_out_ready", way_out_ready, 0);
            check("rst_busy", busy, 0);
        end else begin
            full_m = (q.size() >= 3);
            for (int i = 0; i < 4; i++) elig[i] = unit_req_valid[i] && (unit_req[i].we || !full_m);
            if (lock_m) begin
                g = lock_unit_m; v = elig[g];
            end else begin
                v = 0; g = 0;
                for (int k = 0; k < 4; k++)
                    if (!v && elig[(rr_m + k) % 4]) begin v = 1; g = (rr_m + k) % 4; end
            end
            exp_ready = (v && way_inp_ready) ? 4'(1 << g) : 4'b0;
            check("m_inp_valid", way_inp_valid, v);
            check("m_req_ready", unit_req_ready, exp_ready);
            if (v) begin
                exp_p = unit_req[g];
                exp_p.cache_unit = 2'(g);
                check("m_inp_payload", way_inp, exp_p);
            end
            nonempty = (q.size() > 0);
            exp_rv = (nonempty && way_out_valid) ? 4'(1 << q[0]) : 4'b0;
            exp_or = nonempty && unit_rsp_ready[nonempty ? q[0] : 0];
            check("m_rsp_valid", unit_rsp_valid, exp_rv);
            check("m_out_ready", way_out_ready, exp_or);
            check("m_rsp_data", unit_rsp, way_out);
            check("m_busy", busy, (|unit_req_valid) || nonempty);
            if (nonempty && way_out_valid && exp_or) void'(q.pop_front());
            if (v && way_inp_ready) begin
                rr_m = (g + 1) % 4; lock_m = 0;
                if (!unit_req[g].we) q.push_back(g);
            end else if (v) begin
                lock_m = 1; lock_unit_m = g;
            end
        end
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic set_req(input int u, input bit val, input bit we, input logic [15:0] addr);
        unit_req[u].we         = we;
        unit_req[u].cache_unit = 2'(3 - u);
        unit_req[u].addr       = addr;
        unit_req[u].data       = {addr, ~addr};
        unit_req_valid[u]      = val;
    endtask

    task automatic drain_one(input string name, input logic [3:0] exp_hot, input logic [31:0] d);
        way_out_valid = 1'b1; way_out.data = d;
        #2 check(name, unit_rsp_valid, exp_hot);
        tick;
    endtask

    initial begin
        rst_n = 1'b0; test = 1'b0; unit_req = '0; unit_req_valid = '0;
        way_inp_ready = 1'b1; way_out = '0; way_out_valid = 1'b0; unit_rsp_ready = 4'hF;
        repeat (3) @(posedge clk);
        #3;
        check("reset_inp_valid", way_inp_valid, 0);
        check("reset_busy", busy, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // all four read at once: grants 0,1,2 then unit 3 waits for a freed slot
        for (int u = 0; u < 4; u++) set_req(u, 1, 0, 16'h0100 + 16'(u));
        #2 check("t1_grant0", way_inp.cache_unit, 0); check("t1_ready0", unit_req_ready, 4'b0001); tick;
        unit_req_valid[0] = 0;
        #2 check("t1_grant1", way_inp.cache_unit, 1); check("t1_ready1", unit_req_ready, 4'b0010); tick;
        unit_req_valid[1] = 0;
        #2 check("t1_grant2", way_inp.cache_unit, 2); check("t1_addr2", way_inp.addr, 16'h0102); tick;
        unit_req_valid[2] = 0;
        #2 check("t1_stall", way_inp_valid, 0); check("t1_busy", busy, 1); tick;
        way_out_valid = 1; way_out.data = 32'hD000_0000;
        #2 check("t1_rsp0", unit_rsp_valid, 4'b0001); check("t1_still_stalled", way_inp_valid, 0); tick;
        way_out_valid = 0;
        #2 check("t1_grant3", way_inp.cache_unit, 3); check("t1_ready3", unit_req_ready, 4'b1000); tick;
        unit_req_valid[3] = 0;
        drain_one("t1_rsp1", 4'b0010, 32'hD000_0001);
        drain_one("t1_rsp2", 4'b0100, 32'hD000_0002);
        drain_one("t1_rsp3", 4'b1000, 32'hD000_0003);

        // grant stays on unit 1 while the ways stall, unit 0 follows
        way_out_valid = 0; way_inp_ready = 0; set_req(1, 1, 0, 16'h0211);
        #2 check("t2_hold_a", way_inp.cache_unit, 1); check("t2_no_ready", unit_req_ready, 0); tick;
        set_req(0, 1, 0, 16'h0200);
        #2 check("t2_hold_b", way_inp.cache_unit, 1); check("t2_payload", way_inp.addr, 16'h0211); tick;
        #2 check("t2_hold_c", way_inp.cache_unit, 1); tick;
        way_inp_ready = 1;
        #2 check("t2_hs1", unit_req_ready, 4'b0010); tick;
        unit_req_valid[1] = 0;
        #2 check("t2_grant0", way_inp.cache_unit, 0); check("t2_hs0", unit_req_ready, 4'b0001); tick;
        unit_req_valid[0] = 0;
        drain_one("t2_rsp1", 4'b0010, 32'h2222_0001);
        drain_one("t2_rsp0", 4'b0001, 32'h2222_0000);

        // FIFO full of reads, writes from unit 1 still pass each cycle
        way_out_valid = 0; set_req(0, 1, 0, 16'h0300);
        #2 check("t3_rd0", unit_req_ready, 4'b0001); tick;
        set_req(0, 1, 0, 16'h0301); #2; tick;
        set_req(0, 1, 0, 16'h0302); #2; tick;
        set_req(0, 1, 0, 16'h0303); set_req(WChanUnit, 1, 1, 16'h0310);
        #2 check("t3_wr_a", unit_req_ready, 4'b0010); check("t3_we", way_inp.we, 1); tick;
        set_req(1, 1, 1, 16'h0311);
        #2 check("t3_wr_b", unit_req_ready, 4'b0010); tick;
        set_req(1, 1, 1, 16'h0312);
        #2 check("t3_wr_c", unit_req_ready, 4'b0010); tick;
        unit_req_valid[1] = 0;
        #2 check("t3_still_full", way_inp_valid, 0); tick;
        unit_req_valid[0] = 0;
        for (int k = 0; k < 3; k++) drain_one("t3_rsp", 4'b0001, 32'h3333_0000 + 32'(k));

        // reads from units 2 then 0 route D0 then D1 back in order
        way_out_valid = 0; set_req(EvictUnit, 1, 0, 16'h0420);
        #2 check("t4_grant2", way_inp.cache_unit, 2); tick;
        unit_req_valid[2] = 0; set_req(RChanUnit, 1, 0, 16'h0400);
        #2 check("t4_grant0", way_inp.cache_unit, 0); tick;
        unit_req_valid[0] = 0; way_out_valid = 1; way_out.data = 32'hD0D0_0000;
        #2 check("t4_rsp_d0", unit_rsp_valid, 4'b0100); check("t4_data_d0", unit_rsp.data, 32'hD0D0_0000); tick;
        way_out.data = 32'hD1D1_0001;
        #2 check("t4_rsp_d1", unit_rsp_valid, 4'b0001); check("t4_data_d1", unit_rsp.data, 32'hD1D1_0001); tick;

        // unit 3 at the head holds off its response for two cycles
        way_out_valid = 0; set_req(RefilUnit, 1, 0, 16'h0530);
        #2 check("t5_grant3", way_inp.cache_unit, 3); tick;
        unit_req_valid[3] = 0; unit_rsp_ready = 4'b0111; way_out_valid = 1; way_out.data = 32'h5555_0003;
        #2 check("t5_block_a", way_out_ready, 0); check("t5_valid_a", unit_rsp_valid, 4'b1000); tick;
        #2 check("t5_block_b", way_out_ready, 0); check("t5_valid_b", unit_rsp_valid, 4'b1000); tick;
        unit_rsp_ready = 4'hF;
        #2 check("t5_pop", way_out_ready, 1); tick;
        way_out_valid = 0;
        #2 check("t5_empty", busy, 0); tick;

        // reset with two reads outstanding, arbitration restarts at unit 0
        set_req(1, 1, 0, 16'h0610); set_req(2, 1, 0, 16'h0620);
        #2 check("t6_grant1", way_inp.cache_unit, 1); tick;
        unit_req_valid[1] = 0;
        #2 check("t6_grant2", way_inp.cache_unit, 2); tick;
        unit_req_valid[2] = 0;
        #2 check("t6_busy", busy, 1);
        rst_n = 0;
        #1 check("t6_rst_busy", busy, 0); check("t6_rst_valid", way_inp_valid, 0);
        check("t6_rst_ready", unit_req_ready, 0); check("t6_rst_out_ready", way_out_ready, 0);
        tick; tick;
        rst_n = 1;
        for (int u = 0; u < 4; u++) set_req(u, 1, 0, 16'h0700 + 16'(u));
        #2 check("t6_first_grant", way_inp.cache_unit, 0); check("t6_first_ready", unit_req_ready, 4'b0001); tick;
        unit_req_valid = '0;
        drain_one("t6_rsp0", 4'b0001, 32'h6666_0000);
        way_out_valid = 0;
        #2 check("t6_idle", busy, 0); tick;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
